// File: rtl/imem_loader.sv
// Streaming instruction-memory loader: count header plus 3 bytes per word, then releases the CPU.
// Optional trailing XOR checksum byte is enabled by defining IMEM_LOADER_CSUM_EN.
module imem_loader #(
  parameter int ADDR_W    = 14,
  parameter int WORD_W    = 19,
  parameter int MAX_WORDS = 16384
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              we_IM,
  output logic [WORD_W-1:0] codein,
  output logic [ADDR_W-1:0] immd,
  output logic              cpu_en,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // Bits of the word carried by the first payload byte.
  localparam int HI_W = WORD_W - 16;

  typedef enum logic [3:0] {
    S_IDLE,
    S_HDR_HI,
    S_HDR_LO,
    S_B0,
    S_B1,
    S_B2,
    S_WRITE,
`ifdef IMEM_LOADER_CSUM_EN
    S_CSUM,
`endif
    S_DONE,
    S_ERR
  } state_t;

`ifdef IMEM_LOADER_CSUM_EN
  localparam state_t S_END = S_CSUM;
`else
  localparam state_t S_END = S_DONE;
`endif

  state_t            st, nxt;
  logic [7:0]        hdr_hi;
  logic [15:0]       remain;
  logic [ADDR_W-1:0] addr;
  logic [HI_W-1:0]   w_hi;
  logic [7:0]        w_mid;
  logic              fire;
  logic [15:0]       hdr_cnt;
  logic              nxt_rdy;
`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0]        csum;
`endif

  assign fire    = byte_valid & byte_ready;
  assign hdr_cnt = {hdr_hi, byte_data};

  always_comb begin
    nxt = st;
    unique case (st)
      S_IDLE:   if (start) nxt = S_HDR_HI;
      S_HDR_HI: if (fire) nxt = S_HDR_LO;
      S_HDR_LO: if (fire) begin
        if ({1'b0, hdr_cnt} > 17'(MAX_WORDS)) nxt = S_ERR;
        else if (hdr_cnt == 16'd0)            nxt = S_END;
        else                                  nxt = S_B0;
      end
      S_B0:     if (fire) nxt = (|byte_data[7:HI_W]) ? S_ERR : S_B1;
      S_B1:     if (fire) nxt = S_B2;
      S_B2:     if (fire) nxt = S_WRITE;
      S_WRITE:  nxt = (remain == 16'd1) ? S_END : S_B0;
`ifdef IMEM_LOADER_CSUM_EN
      S_CSUM:   if (fire) nxt = (byte_data == csum) ? S_DONE : S_ERR;
`endif
      S_DONE:   nxt = S_IDLE;
      S_ERR:    nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_comb begin
    nxt_rdy = 1'b0;
    unique case (nxt)
      S_HDR_HI, S_HDR_LO, S_B0, S_B1, S_B2: nxt_rdy = 1'b1;
`ifdef IMEM_LOADER_CSUM_EN
      S_CSUM:                               nxt_rdy = 1'b1;
`endif
      default:                              nxt_rdy = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= S_IDLE;
      byte_ready <= 1'b0;
      we_IM      <= 1'b0;
      codein     <= '0;
      immd       <= '0;
      cpu_en     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      hdr_hi     <= '0;
      remain     <= '0;
      addr       <= '0;
      w_hi       <= '0;
      w_mid      <= '0;
`ifdef IMEM_LOADER_CSUM_EN
      csum       <= '0;
`endif
    end else begin
      st         <= nxt;
      byte_ready <= nxt_rdy;
      busy       <= (nxt != S_IDLE);
      we_IM      <= (nxt == S_WRITE);
      unique case (st)
        S_IDLE: if (start) begin
          done   <= 1'b0;
          err    <= 1'b0;
          cpu_en <= 1'b0;
          addr   <= '0;
`ifdef IMEM_LOADER_CSUM_EN
          csum   <= '0;
`endif
        end
        S_HDR_HI: if (fire) hdr_hi <= byte_data;
        S_HDR_LO: if (fire) remain <= hdr_cnt;
        S_B0:     if (fire) w_hi   <= byte_data[HI_W-1:0];
        S_B1:     if (fire) w_mid  <= byte_data;
        S_B2: if (fire) begin
          codein <= {w_hi, w_mid, byte_data};
          immd   <= addr;
        end
        S_WRITE: begin
          addr   <= addr + 1'b1;
          remain <= remain - 16'd1;
        end
        default: ;
      endcase
`ifdef IMEM_LOADER_CSUM_EN
      if (fire && st != S_CSUM) csum <= csum ^ byte_data;
`endif
      if (nxt == S_DONE) begin
        done   <= 1'b1;
        cpu_en <= 1'b1;
      end
      if (nxt == S_ERR) begin
        err    <= 1'b1;
        cpu_en <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: normal, stalled, header/B0 error, mid-load reset, checksum loads.
`timescale 1ns/1ps
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst, start, byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready, we_IM, cpu_en, busy, done, err;
  logic [18:0] codein;
  logic [13:0] immd;

  int checks = 0;
  int errors = 0;

  logic [7:0]  stim [0:15];
  logic [13:0] wa [$];
  logic [18:0] wd [$];
  logic        prev_we = 1'b0;
  int          wide = 0;

  imem_loader dut (
    .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .we_IM(we_IM), .codein(codein), .immd(immd),
    .cpu_en(cpu_en), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Capture writes away from the active edge; flag any strobe longer than one cycle.
  always @(negedge clk) begin
    if (we_IM) begin
      wa.push_back(immd);
      wd.push_back(codein);
      if (prev_we) wide++;
    end
    prev_we = we_IM;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte was taken plus gap idle cycles.
  task automatic send(input logic [7:0] b, input int gap);
    int n = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("byte_ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  // csum_mode: 0 none, 1 correct checksum, 2 corrupted checksum (only with the checksum build).
  task automatic send_stream(input int n, input int gap, input int csum_mode);
    logic [7:0] x = 8'h00;
    for (int i = 0; i < n; i++) begin
      send(stim[i], gap);
      x = x ^ stim[i];
    end
`ifdef IMEM_LOADER_CSUM_EN
    if (csum_mode != 0) send((csum_mode == 2) ? (x ^ 8'h01) : x, gap);
`else
    if (csum_mode < 0) x = 8'h00;
`endif
  endtask

  task automatic pulse_start();
    wa.delete();
    wd.delete();
    wide = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_ready",  {31'd0, byte_ready}, 32'd0);
    chk("rst_we",     {31'd0, we_IM},      32'd0);
    chk("rst_codein", {13'd0, codein},     32'd0);
    chk("rst_immd",   {18'd0, immd},       32'd0);
    chk("rst_flags",  {28'd0, cpu_en, busy, done, err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Two-word load at full rate
    stim[0] = 8'h00; stim[1] = 8'h02;
    stim[2] = 8'h07; stim[3] = 8'hFF; stim[4] = 8'hFF;
    stim[5] = 8'h00; stim[6] = 8'h01; stim[7] = 8'h23;
    pulse_start();
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    send_stream(8, 0, 1);
    wait_idle();
    chk("t1_nwr", wa.size(), 32'd2);
    if (wa.size() == 2) begin
      chk("t1_a0", {18'd0, wa[0]}, 32'd0);
      chk("t1_d0", {13'd0, wd[0]}, 32'h7FFFF);
      chk("t1_a1", {18'd0, wa[1]}, 32'd1);
      chk("t1_d1", {13'd0, wd[1]}, 32'h00123);
    end
    chk("t1_flags", {29'd0, cpu_en, done, err}, 32'b110);
    chk("t1_hold", {immd, codein}, {14'd1, 19'h00123});

    // Same load with the source stalling every other cycle
    pulse_start();
    chk("t2_cleared", {29'd0, cpu_en, done, err}, 32'b000);
    send_stream(8, 1, 1);
    wait_idle();
    chk("t2_nwr", wa.size(), 32'd2);
    if (wa.size() == 2) begin
      chk("t2_w0", {wa[0], wd[0]}, {14'd0, 19'h7FFFF});
      chk("t2_w1", {wa[1], wd[1]}, {14'd1, 19'h00123});
    end
    chk("t2_wide", wide, 32'd0);
    chk("t2_flags", {29'd0, cpu_en, done, err}, 32'b110);

    // Oversized count
    stim[0] = 8'h40; stim[1] = 8'h01;
    pulse_start();
    send_stream(2, 0, 0);
    wait_idle();
    chk("t3_nwr", wa.size(), 32'd0);
    chk("t3_flags", {29'd0, cpu_en, done, err}, 32'b001);

    // Illegal high bits in B0
    stim[0] = 8'h00; stim[1] = 8'h01; stim[2] = 8'h08;
    pulse_start();
    chk("t4_err_cleared", {31'd0, err}, 32'd0);
    send_stream(3, 0, 0);
    wait_idle();
    chk("t4_nwr", wa.size(), 32'd0);
    chk("t4_flags", {29'd0, cpu_en, done, err}, 32'b001);

    // Reset after B1 of the third word
    stim[0] = 8'h00; stim[1] = 8'h03;
    stim[2] = 8'h01; stim[3] = 8'h11; stim[4] = 8'h11;
    stim[5] = 8'h02; stim[6] = 8'h22; stim[7] = 8'h22;
    stim[8] = 8'h03; stim[9] = 8'h33;
    pulse_start();
    send_stream(10, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_nwr_before", wa.size(), 32'd2);
    chk("t5_rst_out", {byte_ready, we_IM, cpu_en, busy, done, err, immd, codein}, 32'd0);
    @(negedge clk);
    stim[0] = 8'h00; stim[1] = 8'h01;
    stim[2] = 8'h01; stim[3] = 8'h02; stim[4] = 8'h03;
    pulse_start();
    send_stream(5, 0, 1);
    wait_idle();
    chk("t5_nwr", wa.size(), 32'd1);
    if (wa.size() == 1) chk("t5_w0", {wa[0], wd[0]}, {14'd0, 19'h10203});
    chk("t5_flags", {29'd0, cpu_en, done, err}, 32'b110);

`ifdef IMEM_LOADER_CSUM_EN
    // Corrupted checksum: word is written but the load fails
    pulse_start();
    send_stream(5, 0, 2);
    wait_idle();
    chk("t6_nwr", wa.size(), 32'd1);
    chk("t6_flags", {29'd0, cpu_en, done, err}, 32'b001);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
